axi_st_patchkr_param: RTL and testbench
=======================================

Name: axi_st_patchkr_param

Overview:
Parametrised single-clock AXI-ST pattern checker. It packs BEATS_PER_WORD received beats into one word and compares each word against an expected word taken from an internal expected-data FIFO. It counts words and errors, captures the index of the first failing word, and reports pass, fail or timeout. It sits at the receive end of AXI-ST loopback and die-to-die test benches and supersedes the fixed 2x256 dual half-to-full checker.

Parameters:
DATA_WIDTH, 256, width of one AXI-ST beat.
BEATS_PER_WORD, 2, beats packed per compared word; must be >= 1. WORD_W = DATA_WIDTH*BEATS_PER_WORD.
EXP_DEPTH, 16, expected FIFO depth in words; power of 2, >= 2.
CNT_WIDTH, 16, width of word counter, num_words and first_err_idx.
ERR_WIDTH, 9, width of the saturating error counter.
TIMEOUT, 1024, RUN cycles without a beat handshake before the run is aborted; must be > 0.

Ports:
clk  in  1  single clock.
rst  in  1  asynchronous active-high reset.
start  in  1  one-cycle pulse; begins or restarts a run.
cont_en  in  1  1 = continuous mode; 0 = stop after num_words.
num_words  in  CNT_WIDTH  words per run; sampled on start.
exp_valid  in  1  expected word valid.
exp_data  in  WORD_W  expected word.
exp_ready  out  1  expected FIFO can accept a word.
axist_valid  in  1  receive beat valid.
axist_data  in  DATA_WIDTH  receive beat.
axist_tready  out  1  receive ready.
done  out  1  one-cycle pulse on entering DONE.
patchkr_out  out  2  result: 00 idle/running, 11 pass, 10 fail, 01 timeout.
err_count  out  ERR_WIDTH  mismatched words.
word_count  out  CNT_WIDTH  compared words.
first_err_idx  out  CNT_WIDTH  word_count value of the first mismatch.

Behaviour:
- Reset (async, rst=1): state IDLE; FIFO empty; all outputs 0.
- States:
  - IDLE -> RUN on start.
  - RUN -> DONE on termination.
  - DONE -> RUN on start.
  - start while in RUN aborts and restarts the run.
- On a start cycle:
  - Clear word_count, err_count, first_err_idx, beat index and timeout counter.
  - Flush the FIFO; patchkr_out <= 00.
  - exp_ready = 0 during this cycle, so the flush has priority over a simultaneous write.
- exp_ready = ~fifo_full, in IDLE and RUN only; 0 in DONE. Pushing while in IDLE preloads the FIFO.
- axist_tready = (state==RUN) & ~fifo_empty. It never depends on axist_valid.
- Packing: beat k of a word lands at bits [k*DATA_WIDTH +: DATA_WIDTH]; the first beat is the LSB.
- On the handshake of the last beat of a word:
  - The assembled word is compared with the FIFO head, and the head is popped in the same cycle.
  - The next cycle:
    - word_count increments, wrapping modulo 2^CNT_WIDTH.
    - On a mismatch, err_count increments and saturates at all-ones.
    - first_err_idx is loaded on the first mismatch only, with the pre-increment word_count.
- Termination:
  - cont_en=0: enter DONE the cycle after the num_words-th comparison. num_words=0 enters DONE the cycle after start with all counts 0.
  - cont_en=1: a falling edge of cont_en enters DONE at the next word boundary (immediately if beat index is 0). Partial words are discarded.
  - Timeout: the counter increments each RUN cycle without a beat handshake and clears on a handshake. Reaching TIMEOUT enters DONE.
- Result loaded on entering DONE, with precedence:
  - err_count != 0 -> 10
  - else timeout -> 01
  - else 11
- The result is held until the next start.
- done pulses for exactly one cycle on the IDLE/RUN -> DONE transition.

Optional Feature:
AXIST_PATCHKR_TKEEP_EN:
- Defined: adds input axist_tkeep [DATA_WIDTH/8]. Keep bits are packed alongside the data. Only bytes with keep=1 are compared; a word whose keep bits are all 0 counts as matching.
- Undefined: no tkeep port; all bytes are compared.

Decomposition:
- Shared package axi_st_patchkr_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - result codes PATCHKR_IDLE=2'b00, PATCHKR_PASS=2'b11, PATCHKR_FAIL=2'b10, PATCHKR_TMO=2'b01.
- Sub-module axi_st_patchkr_sfifo: synchronous show-ahead FIFO, parametrised width and depth, with a flush input and full/empty outputs.

Test Plan:
- DATA_WIDTH=256, BEATS_PER_WORD=2: preload 8 matching words, start with num_words=8, cont_en=0 -> done after the 8th word, patchkr_out=11, word_count=8, err_count=0.
- Same run with word 3 corrupted at bit 300 -> patchkr_out=10, err_count=1, first_err_idx=3.
- Start with the FIFO empty and axist_valid held at 1 -> axist_tready stays 0; after 1024 cycles done pulses and patchkr_out=01.
- ERR_WIDTH=9, 600 corrupt words in continuous mode, then cont_en falls -> err_count=511 (saturated), patchkr_out=10.
- start mid-run, asserted together with exp_valid -> FIFO is flushed, the write is dropped, counters are 0; the following run passes.
- With AXIST_PATCHKR_TKEEP_EN: a corrupted byte whose keep=0 -> pass; the same byte with keep=1 -> fail.

Source files
------------

// File: rtl/axi_st_patchkr_pkg.sv
// Shared types for the AXI-ST pattern checker: FSM state encoding and result codes.
package axi_st_patchkr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] PATCHKR_IDLE = 2'b00;
    localparam logic [1:0] PATCHKR_PASS = 2'b11;
    localparam logic [1:0] PATCHKR_FAIL = 2'b10;
    localparam logic [1:0] PATCHKR_TMO  = 2'b01;

    // Errors outrank a timeout; a clean run with no timeout is a pass.
    function automatic logic [1:0] patchkr_result(input logic err, input logic tmo);
        if (err)      return PATCHKR_FAIL;
        else if (tmo) return PATCHKR_TMO;
        else          return PATCHKR_PASS;
    endfunction

endpackage

// File: rtl/axi_st_patchkr_sfifo.sv
// Synchronous show-ahead FIFO: rdata always presents the head entry; flush empties it
// and takes priority over a push or pop in the same cycle.
module axi_st_patchkr_sfifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/axi_st_patchkr_param.sv
// AXI-ST pattern checker: packs BEATS_PER_WORD beats per word and compares each against
// an expected-word FIFO. Optional byte-keep masking via `define AXIST_PATCHKR_TKEEP_EN.
module axi_st_patchkr_param
    import axi_st_patchkr_pkg::*;
#(
    parameter int DATA_WIDTH     = 256,
    parameter int BEATS_PER_WORD = 2,
    parameter int EXP_DEPTH      = 16,
    parameter int CNT_WIDTH      = 16,
    parameter int ERR_WIDTH      = 9,
    parameter int TIMEOUT        = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 cont_en,
    input  logic [CNT_WIDTH-1:0]                 num_words,
    input  logic                                 exp_valid,
    input  logic [DATA_WIDTH*BEATS_PER_WORD-1:0] exp_data,
    output logic                                 exp_ready,
    input  logic                                 axist_valid,
    input  logic [DATA_WIDTH-1:0]                axist_data,
`ifdef AXIST_PATCHKR_TKEEP_EN
    input  logic [DATA_WIDTH/8-1:0]              axist_tkeep,
`endif
    output logic                                 axist_tready,
    output logic                                 done,
    output logic [1:0]                           patchkr_out,
    output logic [ERR_WIDTH-1:0]                 err_count,
    output logic [CNT_WIDTH-1:0]                 word_count,
    output logic [CNT_WIDTH-1:0]                 first_err_idx,
    output state_t                               state_dbg
);

    localparam int WORD_W = DATA_WIDTH * BEATS_PER_WORD;
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int BIW    = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam logic [BIW-1:0] LAST_BEAT = BIW'(BEATS_PER_WORD - 1);
    localparam logic [TW-1:0]  TMO_LIMIT = TW'(TIMEOUT);

    state_t               state;
    logic [BIW-1:0]       beat_idx;
    logic [TW-1:0]        tmo_cnt;
    logic [CNT_WIDTH-1:0] num_words_r;
    logic                 cont_q;
    logic                 stop_pend;
    logic [WORD_W-1:0]    word_buf;
    logic [WORD_W-1:0]    asm_word;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [WORD_W-1:0]    fifo_rdata;

    logic                 beat_hs;
    logic                 word_hs;
    logic                 mismatch;
    logic [CNT_WIDTH-1:0] wc_inc;
    logic [ERR_WIDTH-1:0] err_next;
    logic [TW-1:0]        tmo_inc;
    logic                 tmo_hit;
    logic                 stop_req;
    logic                 count_hit;
    logic                 stop_hit;
    logic                 finish;

    // Handshakes: a transfer occurs on a rising clk edge where valid & ready are both high.
    // Ready never looks at valid; valid is expected to hold its data until accepted.
    assign exp_ready    = (state != DONE) & ~fifo_full & ~start;
    assign fifo_push    = exp_valid & exp_ready;
    assign axist_tready = (state == RUN) & ~fifo_empty;
    assign beat_hs      = axist_valid & axist_tready;
    assign word_hs      = beat_hs & (beat_idx == LAST_BEAT);
    assign fifo_pop     = word_hs;
    assign state_dbg    = state;

    axi_st_patchkr_sfifo #(
        .WIDTH (WORD_W),
        .DEPTH (EXP_DEPTH)
    ) u_exp_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start),
        .push  (fifo_push),
        .wdata (exp_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        asm_word = word_buf;
        asm_word[beat_idx*DATA_WIDTH +: DATA_WIDTH] = axist_data;
    end

`ifdef AXIST_PATCHKR_TKEEP_EN
    logic [BEATS_PER_WORD*KEEP_W-1:0] keep_buf;
    logic [BEATS_PER_WORD*KEEP_W-1:0] asm_keep;
    logic [WORD_W-1:0]                cmp_mask;

    // Bytes with keep=0 drop out of the compare, so an all-zero keep word always matches.
    always_comb begin
        asm_keep = keep_buf;
        asm_keep[beat_idx*KEEP_W +: KEEP_W] = axist_tkeep;
        cmp_mask = '0;
        for (int b = 0; b < BEATS_PER_WORD*KEEP_W; b++) begin
            cmp_mask[b*8 +: 8] = {8{asm_keep[b]}};
        end
    end

    assign mismatch = |((asm_word ^ fifo_rdata) & cmp_mask);
`else
    assign mismatch = (asm_word != fifo_rdata);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_buf <= '0;
`ifdef AXIST_PATCHKR_TKEEP_EN
            keep_buf <= '0;
`endif
        end else if (beat_hs && !start) begin
            word_buf <= asm_word;
`ifdef AXIST_PATCHKR_TKEEP_EN
            keep_buf <= asm_keep;
`endif
        end
    end

    assign wc_inc    = word_count + CNT_WIDTH'(1);
    assign err_next  = (word_hs && mismatch && !(&err_count)) ? err_count + ERR_WIDTH'(1) : err_count;
    assign tmo_inc   = tmo_cnt + TW'(1);
    assign tmo_hit   = ~beat_hs & (tmo_inc == TMO_LIMIT);
    // A stop request waits for a word boundary; a word completing this cycle still counts.
    assign stop_req  = stop_pend | (cont_q & ~cont_en);
    assign count_hit = ~cont_en & word_hs & (wc_inc == num_words_r);
    assign stop_hit  = stop_req & ((beat_idx == '0) | word_hs);
    assign finish    = count_hit | stop_hit | tmo_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            beat_idx      <= '0;
            tmo_cnt       <= '0;
            num_words_r   <= '0;
            cont_q        <= 1'b0;
            stop_pend     <= 1'b0;
            done          <= 1'b0;
            patchkr_out   <= PATCHKR_IDLE;
            err_count     <= '0;
            word_count    <= '0;
            first_err_idx <= '0;
        end else begin
            done   <= 1'b0;
            cont_q <= cont_en;
            if (start) begin
                word_count    <= '0;
                err_count     <= '0;
                first_err_idx <= '0;
                beat_idx      <= '0;
                tmo_cnt       <= '0;
                stop_pend     <= 1'b0;
                num_words_r   <= num_words;
                if (!cont_en && num_words == '0) begin
                    state       <= DONE;
                    done        <= 1'b1;
                    patchkr_out <= PATCHKR_PASS;
                end else begin
                    state       <= RUN;
                    patchkr_out <= PATCHKR_IDLE;
                end
            end else if (state == RUN) begin
                if (beat_hs) begin
                    beat_idx <= (beat_idx == LAST_BEAT) ? '0 : beat_idx + BIW'(1);
                    tmo_cnt  <= '0;
                end else begin
                    tmo_cnt  <= tmo_inc;
                end
                if (word_hs) begin
                    word_count <= wc_inc;
                    err_count  <= err_next;
                    if (mismatch && err_count == '0) first_err_idx <= word_count;
                end
                if (cont_q && !cont_en) stop_pend <= 1'b1;
                if (finish) begin
                    state       <= DONE;
                    done        <= 1'b1;
                    patchkr_out <= patchkr_result(err_next != '0, tmo_hit);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_st_patchkr_param.sv
// Directed bench for axi_st_patchkr_param: table of whole runs plus hand-written
// sequences for timeout, restart, continuous-mode stop, saturation and byte keep.
module tb_axi_st_patchkr_param;
  import axi_st_patchkr_pkg::*;

  localparam int DW    = 256;
  localparam int BPW   = 2;
  localparam int WW    = DW * BPW;
  localparam int DEPTH = 16;
  localparam int CW    = 16;
  localparam int EW    = 9;
  localparam int TMO   = 1024;

  logic          clk;
  logic          rst;
  logic          start;
  logic          cont_en;
  logic [CW-1:0] num_words;
  logic          exp_valid;
  logic [WW-1:0] exp_data;
  logic          exp_ready;
  logic          axist_valid;
  logic [DW-1:0] axist_data;
  logic          axist_tready;
  logic          done;
  logic [1:0]    patchkr_out;
  logic [EW-1:0] err_count;
  logic [CW-1:0] word_count;
  logic [CW-1:0] first_err_idx;
  state_t        state_dbg;
`ifdef AXIST_PATCHKR_TKEEP_EN
  logic [DW/8-1:0] axist_tkeep;
`endif

  axi_st_patchkr_param #(
    .DATA_WIDTH(DW), .BEATS_PER_WORD(BPW), .EXP_DEPTH(DEPTH),
    .CNT_WIDTH(CW), .ERR_WIDTH(EW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cont_en(cont_en), .num_words(num_words),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .axist_valid(axist_valid), .axist_data(axist_data),
`ifdef AXIST_PATCHKR_TKEEP_EN
    .axist_tkeep(axist_tkeep),
`endif
    .axist_tready(axist_tready), .done(done), .patchkr_out(patchkr_out),
    .err_count(err_count), .word_count(word_count), .first_err_idx(first_err_idx),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [WW-1:0] exp_q[$];

  always @(posedge clk) if (done) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] gen_word(input int seed, input int idx);
    logic [WW-1:0] w;
    for (int j = 0; j < WW/32; j++) w[j*32 +: 32] = (32'(j+1) * 32'h9E3779B9) ^ 32'(seed*65536 + idx);
    return w;
  endfunction

  // driver tasks
  task automatic pulse_start(input int nw, input logic ce);
    num_words = CW'(nw);
    cont_en   = ce;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_word(input logic [WW-1:0] w);
    exp_data  = w;
    exp_valid = 1'b1;
    @(negedge clk);
    check("push_ready", exp_ready, 1'b1);
    @(posedge clk); #1;
    exp_valid = 1'b0;
    exp_q.push_back(w);
  endtask

  task automatic drive_beat(input logic [DW-1:0] d);
    logic got;
    got = 1'b0;
    axist_data  = d;
    axist_valid = 1'b1;
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge clk);
      if (axist_tready) got = 1'b1;
      @(posedge clk); #1;
    end
    axist_valid = 1'b0;
    check("beat_accept", got, 1'b1);
  endtask

  task automatic send_next(input int bad_bit, input logic bad);
    logic [WW-1:0] w;
    w = exp_q.pop_front();
    if (bad) w[bad_bit] = ~w[bad_bit];
    for (int k = 0; k < BPW; k++) drive_beat(w[k*DW +: DW]);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, done, 1'b1);
  endtask

  task automatic check_final(input string name, input logic [1:0] res, input int wc,
                             input int ec, input int fe, input int d0);
    check({name, "_result"}, patchkr_out, res);
    check({name, "_word_count"}, word_count, 64'(wc));
    check({name, "_err_count"}, err_count, 64'(ec));
    check({name, "_first_err"}, first_err_idx, 64'(fe));
    repeat (3) @(negedge clk);
    check({name, "_state"}, state_dbg, DONE);
    check({name, "_exp_ready"}, exp_ready, 1'b0);
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_held"}, patchkr_out, res);
  endtask

  typedef struct {
    int          n_push;
    int          num;
    logic [31:0] bad_mask;
    int          bad_bit;
    logic [1:0]  res;
    int          wc;
    int          ec;
    int          fe;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int d0;
    int cyc;
    int tready_seen;
    int done_seen;
    logic [WW-1:0] w;

    vecs[0] = '{8,  8,  32'h00, 0,   PATCHKR_PASS, 8,  0, 0};
    vecs[1] = '{8,  8,  32'h08, 300, PATCHKR_FAIL, 8,  1, 3};
    vecs[2] = '{5,  5,  32'h10, 511, PATCHKR_FAIL, 5,  1, 4};
    vecs[3] = '{0,  0,  32'h00, 0,   PATCHKR_PASS, 0,  0, 0};
    vecs[4] = '{3,  3,  32'h01, 256, PATCHKR_FAIL, 3,  1, 0};
    vecs[5] = '{16, 16, 32'h00, 0,   PATCHKR_PASS, 16, 0, 0};
    vecs[6] = '{6,  6,  32'h2A, 17,  PATCHKR_FAIL, 6,  3, 1};
    vecs[7] = '{4,  2,  32'h00, 0,   PATCHKR_PASS, 2,  0, 0};
    vecs[8] = '{4,  4,  32'h08, 0,   PATCHKR_FAIL, 4,  1, 3};

    rst = 1'b1; start = 1'b0; cont_en = 1'b0; num_words = '0;
    exp_valid = 1'b0; exp_data = '0; axist_valid = 1'b0; axist_data = '0;
`ifdef AXIST_PATCHKR_TKEEP_EN
    axist_tkeep = '1;
`endif
    repeat (3) @(negedge clk);
    check("rst_result", patchkr_out, PATCHKR_IDLE);
    check("rst_done", done, 1'b0);
    check("rst_err_count", err_count, 0);
    check("rst_word_count", word_count, 0);
    check("rst_first_err", first_err_idx, 0);
    check("rst_tready", axist_tready, 1'b0);
    check("rst_state", state_dbg, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;

    // table of whole non-continuous runs
    for (int v = 0; v < 9; v++) begin
      d0 = done_cnt;
      pulse_start(vecs[v].num, 1'b0);
      for (int i = 0; i < vecs[v].n_push; i++) push_word(gen_word(v, i));
      if (vecs[v].n_push == DEPTH) check($sformatf("v%0d_full", v), exp_ready, 1'b0);
      for (int i = 0; i < vecs[v].num; i++) send_next(vecs[v].bad_bit, vecs[v].bad_mask[i]);
      wait_done($sformatf("v%0d", v), 50);
      check_final($sformatf("v%0d", v), vecs[v].res, vecs[v].wc, vecs[v].ec, vecs[v].fe, d0);
    end

    // timeout with empty FIFO and valid held high
    d0 = done_cnt;
    axist_data  = {8{$urandom}};
    axist_valid = 1'b1;
    pulse_start(4, 1'b0);
    cyc = 0;
    tready_seen = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (axist_tready) tready_seen++;
    end
    check("tmo_tready_seen", 64'(tready_seen), 0);
    check("tmo_cycles", 64'(cyc), 64'(TMO + 1));
    axist_valid = 1'b0;
    check_final("tmo", PATCHKR_TMO, 0, 0, 0, d0);

    // restart mid-run together with an expected-word write
    pulse_start(4, 1'b0);
    push_word(gen_word(20, 0));
    push_word(gen_word(20, 1));
    send_next(0, 1'b0);
    send_next(5, 1'b1);
    @(negedge clk);
    check("pre_restart_err", err_count, 1);
    check("pre_restart_first_err", first_err_idx, 1);
    check("pre_restart_word_count", word_count, 2);
    num_words = CW'(2);
    start     = 1'b1;
    exp_valid = 1'b1;
    exp_data  = gen_word(20, 9);
    @(negedge clk);
    check("restart_exp_ready", exp_ready, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    exp_valid = 1'b0;
    exp_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    check("restart_word_count", word_count, 0);
    check("restart_err_count", err_count, 0);
    check("restart_first_err", first_err_idx, 0);
    check("restart_result", patchkr_out, PATCHKR_IDLE);
    check("restart_tready", axist_tready, 1'b0);
    check("restart_state", state_dbg, RUN);
    @(posedge clk); #1;
    push_word(gen_word(21, 0));
    push_word(gen_word(21, 1));
    send_next(0, 1'b0);
    send_next(0, 1'b0);
    wait_done("restart", 50);
    check_final("restart", PATCHKR_PASS, 2, 0, 0, d0);

    // continuous mode: cont_en falls mid-word, run ends once that word completes
    d0 = done_cnt;
    pulse_start(0, 1'b1);
    for (int i = 0; i < 3; i++) push_word(gen_word(30, i));
    send_next(0, 1'b0);
    send_next(0, 1'b0);
    w = exp_q.pop_front();
    drive_beat(w[0 +: DW]);
    cont_en = 1'b0;
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("cont_wait_no_done", 64'(done_seen), 0);
    check("cont_wait_word_count", word_count, 2);
    @(posedge clk); #1;
    drive_beat(w[DW +: DW]);
    wait_done("cont", 50);
    check_final("cont", PATCHKR_PASS, 3, 0, 0, d0);

    // continuous mode, 600 bad words: error counter saturates
    d0 = done_cnt;
    pulse_start(0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      push_word(gen_word(40, i));
      send_next(i % WW, 1'b1);
    end
    cont_en = 1'b0;
    wait_done("sat", 50);
    check_final("sat", PATCHKR_FAIL, 600, (1 << EW) - 1, 0, d0);

`ifdef AXIST_PATCHKR_TKEEP_EN
    // byte 37 corrupted with keep=0 passes; an all-zero keep word matches anything
    d0 = done_cnt;
    pulse_start(2, 1'b0);
    push_word(gen_word(50, 0));
    push_word(gen_word(50, 1));
    w = exp_q.pop_front();
    w[300] = ~w[300];
    drive_beat(w[0 +: DW]);
    axist_tkeep = ~(32'd1 << 5);
    drive_beat(w[DW +: DW]);
    axist_tkeep = '0;
    w = exp_q.pop_front();
    drive_beat(~w[0 +: DW]);
    drive_beat(~w[DW +: DW]);
    axist_tkeep = '1;
    wait_done("keep0", 50);
    check_final("keep0", PATCHKR_PASS, 2, 0, 0, d0);

    d0 = done_cnt;
    pulse_start(1, 1'b0);
    push_word(gen_word(50, 0));
    send_next(300, 1'b1);
    wait_done("keep1", 50);
    check_final("keep1", PATCHKR_FAIL, 1, 1, 0, d0);
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
